// File: rtl/dcache_line_memory.sv
// Line-granular data memory behind the data cache: fixed-latency read/write of
// whole cache lines, completed by a single-cycle ack pulse.
module dcache_line_memory #(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 512,
  parameter int unsigned LINE_BITS   = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam logic [7:0]  LAT8  = LATENCY[7:0];

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] data_q, data_d;
  logic                 ack_q, ack_d;
  logic                 mem_we;

  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  // Offset bits and index bits above the array size never select a line.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[5+IDX_W-1:5];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = 8'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAT8) begin
          ack_d   = 1'b1;
          state_d = ACK;
          if (wr_q) mem_we = 1'b1;
          else      data_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  // Array has no reset; an aborted request never reaches the commit cycle.
  always_ff @(posedge clk_i) begin
    if (mem_we && rst_i) mem_q[idx_q] <= wdata_q;
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

endmodule
